// File: rtl/l2_burst_responder_pkg.sv
// Shared constants and types for the L2 burst responder: state encoding,
// default buffer depth and the burst-length clamp.
package l2_burst_responder_pkg;

    localparam int MAX_BURST_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Requested word count limited to what the buffer can hold
    function automatic int clamp_len(input logic [4:0] size, input int max_burst);
        int s;
        s = int'(size);
        return (s > max_burst) ? max_burst : s;
    endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// L1-facing request/stream signals and backing-memory word port, bundled so the
// responder and its environment share one connection.
interface l2_burst_responder_if;

    logic        l2_rreq;
    logic [31:0] l2_addr;
    logic [4:0]  l2_burst_size;
    logic [31:0] l2_rdata;
    logic        l2_busy;
    logic        mem_rreq;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  l2_rreq, l2_addr, l2_burst_size, mem_rdata, mem_ack,
        output l2_rdata, l2_busy, mem_rreq, mem_addr
    );

    modport master (
        output l2_rreq, l2_addr, l2_burst_size, mem_rdata, mem_ack,
        input  l2_rdata, l2_busy, mem_rreq, mem_addr
    );

endinterface

// File: rtl/l2_burst_responder_buf.sv
// Burst word buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every word is written before it is read.
module l2_burst_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_r [DEPTH];

    // Capture one fetched word per acknowledged memory read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_addr) < DEPTH) ? mem_r[rd_addr] : 32'h0000_0000;

endmodule

// File: rtl/l2_burst_responder.sv
// Burst read responder: fetches LEN words from backing memory into a local
// buffer while busy, then streams them to L1 one word per cycle without stalls.
module l2_burst_responder
    import l2_burst_responder_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_burst_responder_if.slave  bus
);

    localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int IW = $clog2(MAX_BURST) + 1;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

    state_e        state_r, state_n;
    logic [IW-1:0] len_r, len_n;
    logic [IW-1:0] fidx_r, fidx_n;
    logic [IW-1:0] sidx_r, sidx_n;
    logic          busy_r, busy_n;
    logic          mem_rreq_r, mem_rreq_n;
    logic [31:0]   mem_addr_r, mem_addr_n;
    logic          wr_en_s;
    logic [31:0]   buf_rdata_s;
    logic          unused_s;

    // The byte offset of the start address is dropped when forming the word base
    assign unused_s = ^bus.l2_addr[1:0];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            len_r      <= IDX_ZERO;
            fidx_r     <= IDX_ZERO;
            sidx_r     <= IDX_ZERO;
            busy_r     <= 1'b0;
            mem_rreq_r <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_n;
            len_r      <= len_n;
            fidx_r     <= fidx_n;
            sidx_r     <= sidx_n;
            busy_r     <= busy_n;
            mem_rreq_r <= mem_rreq_n;
            mem_addr_r <= mem_addr_n;
        end
    end

    // Next-state and next-register logic for the fetch/stream sequence
    always_comb begin
        state_n    = state_r;
        len_n      = len_r;
        fidx_n     = fidx_r;
        sidx_n     = sidx_r;
        busy_n     = busy_r;
        mem_rreq_n = mem_rreq_r;
        mem_addr_n = mem_addr_r;
        wr_en_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.l2_rreq && (bus.l2_burst_size != 5'd0)) begin
                    state_n    = ST_FETCH;
                    len_n      = IW'(clamp_len(bus.l2_burst_size, MAX_BURST));
                    fidx_n     = IDX_ZERO;
                    sidx_n     = IDX_ZERO;
                    busy_n     = 1'b1;
                    mem_rreq_n = 1'b1;
                    mem_addr_n = {bus.l2_addr[31:2], 2'b00};
                end else begin
                    busy_n     = 1'b0;
                    mem_rreq_n = 1'b0;
                end
            end

            ST_FETCH: begin
                if (bus.mem_ack && mem_rreq_r) begin
                    wr_en_s    = 1'b1;
                    fidx_n     = fidx_r + IDX_ONE;
                    mem_addr_n = mem_addr_r + 32'd4;
                    if (fidx_r == (len_r - IDX_ONE)) begin
                        state_n    = ST_STREAM;
                        sidx_n     = IDX_ZERO;
                        busy_n     = 1'b0;
                        mem_rreq_n = 1'b0;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end else begin
                    state_n = ST_FETCH;
                end
            end

            ST_STREAM: begin
                // One word per cycle; the last word's cycle hands back to IDLE
                if (sidx_r == (len_r - IDX_ONE)) begin
                    state_n = ST_IDLE;
                    sidx_n  = IDX_ZERO;
                    fidx_n  = IDX_ZERO;
                end else begin
                    state_n = ST_STREAM;
                    sidx_n  = sidx_r + IDX_ONE;
                end
            end

            default: begin
                state_n    = ST_IDLE;
                busy_n     = 1'b0;
                mem_rreq_n = 1'b0;
                fidx_n     = IDX_ZERO;
                sidx_n     = IDX_ZERO;
            end
        endcase
    end

    l2_burst_buf #(
        .DEPTH (MAX_BURST),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (fidx_r[AW-1:0]),
        .wr_data (bus.mem_rdata),
        .rd_addr (sidx_r[AW-1:0]),
        .rd_data (buf_rdata_s)
    );

    assign bus.l2_busy  = busy_r;
    assign bus.mem_rreq = mem_rreq_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.l2_rdata = (state_r == ST_STREAM) ? buf_rdata_s : 32'h0000_0000;

endmodule

// File: doc/l2_burst_responder.md
L2_BURST_RESPONDER -- requirements
Module: l2_burst_responder

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning buffer depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port l2_rreq  input  1  single-cycle burst read request from L1.
REQ-005 SHALL have port l2_addr  input  32  burst start byte address, sampled with l2_rreq.
REQ-006 SHALL have port l2_burst_size  input  5  requested word count, sampled with l2_rreq.
REQ-007 SHALL have port l2_rdata  output  32  streamed read word.
REQ-008 SHALL have port l2_busy  output  1  high while a burst is being fetched.
REQ-009 SHALL have port mem_rreq  output  1  backing-memory word read request (level).
REQ-010 SHALL have port mem_addr  output  32  backing-memory word address.
REQ-011 SHALL have port mem_rdata  input  32  backing-memory read data, valid with mem_ack.
REQ-012 SHALL have port mem_ack  input  1  single-cycle strobe completing one mem_rreq word.

Function
REQ-013 SHALL implement states IDLE, FETCH, STREAM.
REQ-014 IDLE: on edge with l2_rreq=1 and l2_burst_size!=0, SHALL latch base={l2_addr[31:2],2'b00}, LEN=min(l2_burst_size,MAX_BURST), set l2_busy=1 at that same edge, enter FETCH.
REQ-015 IDLE: l2_rreq with l2_burst_size=0 SHALL be ignored (l2_busy stays 0, no memory access).
REQ-016 FETCH: mem_rreq SHALL be 1 with mem_addr=base+4*fidx (modulo 2^32, wrap-around permitted); fidx starts at 0.
REQ-017 FETCH: each mem_ack SHALL write mem_rdata into buffer[fidx] and increment fidx; mem_addr SHALL advance the cycle after the ack.
REQ-018 FETCH: on the ack with fidx=LEN-1, SHALL drop mem_rreq and l2_busy at that edge and enter STREAM with sidx=0.
REQ-019 STREAM: l2_rdata SHALL equal buffer[sidx] combinationally; sidx SHALL increment every cycle with no stall.
REQ-020 Word k of the burst SHALL appear on l2_rdata exactly k cycles after the first cycle l2_busy is low.
REQ-021 STREAM: after the cycle presenting word LEN-1, SHALL return to IDLE.
REQ-022 l2_rdata SHALL be 32'h0 in IDLE and FETCH.
REQ-023 l2_rreq arriving in FETCH or STREAM SHALL be ignored with no effect on the current burst.
REQ-024 mem_ack while mem_rreq=0 SHALL be ignored.
REQ-025 l2_busy SHALL be 1 in FETCH only; minimum busy duration SHALL equal LEN memory acks.

Reset
REQ-026 Reset SHALL force IDLE, l2_busy=0, mem_rreq=0, mem_addr=0, l2_rdata=0, fidx=sidx=0.
REQ-027 Reset mid-FETCH or mid-STREAM SHALL abandon the burst; a late mem_ack after reset SHALL be ignored.
REQ-028 Buffer contents SHALL NOT require reset.

Structure
REQ-029 Shared package SHALL hold state encoding constants and MAX_BURST default.
REQ-030 SHALL instantiate one sub-module l2_burst_buf: MAX_BURST x 32 register file, one synchronous write port, one combinational read port.
REQ-031 Index counters SHALL be $clog2(MAX_BURST)+1 bits to represent LEN=MAX_BURST.

Verification
REQ-032 rreq, addr=0x0000_1234, size=8, mem acks every cycle -> mem_addr 0x1234..0x1250 step 4 (bits[1:0]=0 from base 0x1234), busy high 8 cycles, then words 0..7 on 8 consecutive cycles.
REQ-033 Same burst with mem_ack gaps of 0..3 random cycles -> identical l2_rdata sequence, busy low only after 8th ack.
REQ-034 size=20 at addr 0xFFFF_FFF0 -> LEN=16, mem_addr wraps 0xFFFF_FFFC->0x0000_0000, 16 words streamed.
REQ-035 size=0 -> busy never rises, mem_rreq never rises; rreq during FETCH -> ignored, first burst completes unchanged.
REQ-036 Reset after 3 acks, then stray mem_ack, then new size=8 burst -> stray ignored, new burst correct from word 0.
REQ-037 Back-to-back: rreq in cycle after STREAM ends -> accepted, second burst correct with L1-style capture timing.
